uart_tx_responder: RTL

- Memory-mapped UART transmitter that answers the FemtoRV32 memory bus as a responder in the IO region.
- The CPU writes bytes into an internal FIFO. The block serializes them as 8N1 frames on tx_out.
- It drives mem_rbusy/mem_wbusy-style handshakes so software can stream bytes without polling while FIFO space remains.
- It sits beside UART_Component in the SoC IO decode, selected by an io_device slot.

---
 rtl/uart_tx_responder_if.sv | 23 ++
 rtl/uart_tx_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_responder_if.sv
// Bus-side handshake bundle between the CPU IO decode and uart_tx_responder.
// The CPU side drives select, address, write mask/data and the read strobe.
// The device side answers with read data and the two busy flags.
interface uart_tx_responder_if;
   logic        cs;
   logic [1:0]  addr;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic        rstrb;
   logic [31:0] rdata;
   logic        rbusy;
   logic        wbusy;

   modport master (
      output cs, addr, wmask, wdata, rstrb,
      input  rdata, rbusy, wbusy
   );

   modport slave (
      input  cs, addr, wmask, wdata, rstrb,
      output rdata, rbusy, wbusy
   );
endinterface

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter for the IO region.
// The CPU writes bytes into a small circular FIFO. A four-state FSM pops
// bytes and shifts them out LSB first, at DIV clocks per bit.
// A write to a full FIFO parks the byte in a one-entry pending register and
// raises wbusy until a pop frees a slot.
// DIV is rounded from CLK_HZ/BAUD and must be at least 2.
// FIFO_DEPTH must be a power of two and at least 2.
module uart_tx_responder #(
   parameter int CLK_HZ     = 10_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_responder_if.slave bus,
   output logic               tx_out,
   output logic               irq
);

   localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CW   = $clog2(DIV);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;

   localparam logic [CW-1:0]   DIV_M1  = CW'(DIV - 1);
   localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   // FIFO storage and bookkeeping
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            empty;
   logic            full;

   // Pending write parked while the FIFO is full
   logic            pend_valid;
   logic [7:0]      pend_byte;

   // Control and read-side registers
   logic            irq_en;
   logic            rbusy_q;
   logic [31:0]     rdata_q;
   logic [31:0]     rd_value;
   logic [31:0]     status_word;
   logic [3:0]      cnt_sat;

   // Transmitter state
   tx_state_t       state;
   tx_state_t       state_nx;
   logic [CW-1:0]   baud_cnt;
   logic [CW-1:0]   baud_nx;
   logic [2:0]      bit_idx;
   logic [2:0]      bit_nx;
   logic [7:0]      shreg;
   logic [7:0]      shreg_nx;
   logic            tx_nx;
   logic            tx_active;

   // Request decode and FIFO control strobes
   logic            wr_req;
   logic            data_wr;
   logic            ctrl_wr;
   logic            flush;
   logic            can_pop;
   logic            pop;
   logic            push_direct;
   logic            push_pend;
   logic            push;
   logic            latch_pend;
   logic [7:0]      push_byte;

   // Upper write-data bits carry nothing for this device.
   logic            unused_wdata;
   assign unused_wdata = ^bus.wdata[31:8];

   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign tx_active = (state != S_IDLE);

   // While a byte is pending the CPU is held off, so every write is dropped.
   assign wr_req  = bus.cs & (|bus.wmask) & ~pend_valid;
   assign data_wr = wr_req & (bus.addr == A_DATA) & bus.wmask[0];
   assign ctrl_wr = wr_req & (bus.addr == A_CTRL) & bus.wmask[0];
   assign flush   = ctrl_wr & bus.wdata[1];

   // A flush in the same cycle suppresses the pop, so nothing queued escapes.
   assign can_pop = ~empty & ~flush;

   // A direct write may land on a full FIFO when a pop frees the slot this cycle.
   assign push_direct = data_wr & (~full | pop);
   assign push_pend   = pend_valid & (~full | pop);
   assign push        = (push_direct | push_pend) & ~flush;
   assign push_byte   = pend_valid ? pend_byte : bus.wdata[7:0];
   assign latch_pend  = data_wr & full & ~pop;

   // STATUS view; the count field saturates so deep FIFOs still fit the nibble.
   assign cnt_sat     = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
   assign status_word = {24'b0, cnt_sat, irq_en, tx_active, full, empty};

   // Select the register value captured by a read request.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rd_value = '0;
      case (bus.addr)
         A_STATUS: rd_value = status_word;
         A_CTRL:   rd_value = {31'b0, irq_en};
         default:  rd_value = '0;
      endcase
   end

   // FIFO storage write port.
   // NOTE: the storage array has no reset; count gates every read, so stale
   // contents are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_byte;
      end
   end

   // FIFO pointers and occupancy; flush wins over any push.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Pending write register: parks a byte aimed at a full FIFO, drives wbusy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_byte  <= '0;
      end else if (flush) begin
         pend_valid <= 1'b0;
      end else if (latch_pend) begin
         pend_valid <= 1'b1;
         pend_byte  <= bus.wdata[7:0];
      end else if (push_pend) begin
         pend_valid <= 1'b0;
      end
   end

   // Control register and the registered drain interrupt.
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en <= bus.wdata[0];
         end
         irq <= irq_en & empty & ~tx_active;
      end
   end

   // Two-cycle read handshake: capture and flag busy, then release busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rbusy_q <= 1'b0;
         rdata_q <= '0;
      end else if (rbusy_q) begin
         rbusy_q <= 1'b0;
      end else if (bus.cs && bus.rstrb) begin
         rbusy_q <= 1'b1;
         rdata_q <= rd_value;
      end
   end

   assign bus.rbusy = rbusy_q;
   assign bus.rdata = rdata_q;
   assign bus.wbusy = pend_valid;

   // Transmitter registers, including the registered line output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx_out   <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_idx  <= bit_nx;
         shreg    <= shreg_nx;
         tx_out   <= tx_nx;
      end
   end

   // Transmitter next state: the line level is chosen together with the state,
   // so each bit period starts on the same edge as its state change.
   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_idx;
      shreg_nx = shreg;
      tx_nx    = tx_out;
      pop      = 1'b0;

      case (state)
         S_IDLE: begin
            tx_nx = 1'b1;
            if (can_pop) begin
               pop      = 1'b1;
               shreg_nx = mem[rd_ptr];
               baud_nx  = DIV_M1;
               state_nx = S_START;
               tx_nx    = 1'b0;
            end
         end

         S_START: begin
            if (baud_cnt == '0) begin
               baud_nx  = DIV_M1;
               bit_nx   = 3'd0;
               state_nx = S_DATA;
               tx_nx    = shreg[0];
            end else begin
               baud_nx = baud_cnt - 1'b1;
            end
         end

         S_DATA: begin
            if (baud_cnt == '0) begin
               baud_nx = DIV_M1;
               if (bit_idx == 3'd7) begin
                  state_nx = S_STOP;
                  tx_nx    = 1'b1;
               end else begin
                  bit_nx   = bit_idx + 1'b1;
                  shreg_nx = {1'b0, shreg[7:1]};
                  tx_nx    = shreg[1];
               end
            end else begin
               baud_nx = baud_cnt - 1'b1;
            end
         end

         S_STOP: begin
            if (baud_cnt == '0) begin
               if (can_pop) begin
                  // Back-to-back frame: next start bit follows with no idle gap.
                  pop      = 1'b1;
                  shreg_nx = mem[rd_ptr];
                  baud_nx  = DIV_M1;
                  state_nx = S_START;
                  tx_nx    = 1'b0;
               end else begin
                  state_nx = S_IDLE;
                  tx_nx    = 1'b1;
               end
            end else begin
               baud_nx = baud_cnt - 1'b1;
            end
         end

         default: begin
            state_nx = S_IDLE;
            tx_nx    = 1'b1;
         end
      endcase
   end

endmodule
